noc_input_port_router: RTL

Ingress half of a router port: accepts one flit stream from a neighbouring link and buffers it in a FIFO. Computes the XY route from the header flit, requests the selected one of the five output switches, and forwards the packet there once granted. Packets are delivered header-to-tail without interleaving. This is the requesting/sending side of the output switch's 5-way receiver and grant interface.

---
 rtl/noc_input_port_router.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/noc_input_port_router.sv
// Router ingress port: input FIFO, XY route and packet-atomic switch request/send.
// Optional forwarded-packet counter enabled by defining NOC_IN_PORT_PKT_CNT_EN.
module noc_input_port_router #(
   parameter int FLIT_WIDTH  = 130,
   parameter int DEPTH       = 4,
   parameter int COORD_WIDTH = 4,
   parameter int MY_X        = 0,
   parameter int MY_Y        = 0
) (
   input  logic                  noc_clk,
   input  logic                  noc_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   output logic [4:0]            o_request,
   input  logic [4:0]            i_grant,
   output logic [4:0]            out_valid,
   output logic [FLIT_WIDTH-1:0] out_flit,
   input  logic [4:0]            out_ready,
   output logic                  o_drop,
   output logic [15:0]           o_pkt_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [COORD_WIDTH-1:0] MX = COORD_WIDTH'(MY_X);
   localparam logic [COORD_WIDTH-1:0] MY = COORD_WIDTH'(MY_Y);

   localparam logic [4:0] P_LOCAL = 5'b00001;
   localparam logic [4:0] P_EAST  = 5'b00010;
   localparam logic [4:0] P_WEST  = 5'b00100;
   localparam logic [4:0] P_NORTH = 5'b01000;
   localparam logic [4:0] P_SOUTH = 5'b10000;

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t state, state_nxt;

   logic [FLIT_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic                  full, empty;
   logic                  push, pop;
   logic                  fwd_pop, drop_pop;
   logic [FLIT_WIDTH-1:0] head;
   logic                  head_hdr, head_tail;
   logic [COORD_WIDTH-1:0] hd_x, hd_y;
   logic                  x_eq;
   logic [4:0]            route;
   logic [4:0]            port;
   logic                  port_ld;
   logic                  drop_q;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = !full && !noc_rst;
   assign push      = in_valid && in_ready;
   assign pop       = fwd_pop || drop_pop;

   assign head      = mem[rd_ptr];
   assign out_flit  = head;
   assign head_hdr  = head[FLIT_WIDTH-1];
   assign head_tail = head[FLIT_WIDTH-2];
   assign hd_x      = head[COORD_WIDTH-1:0];
   assign hd_y      = head[2*COORD_WIDTH-1:COORD_WIDTH];
   assign x_eq      = (hd_x == MX);

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge noc_clk) begin
      if (push) mem[wr_ptr] <= in_flit;
   end

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // X first, then Y; conditions are mutually exclusive.
   always_comb begin
      route = P_LOCAL;
      unique case (1'b1)
         (hd_x > MX):          route = P_EAST;
         (hd_x < MX):          route = P_WEST;
         (x_eq && hd_y > MY):  route = P_NORTH;
         (x_eq && hd_y < MY):  route = P_SOUTH;
         default:              route = P_LOCAL;
      endcase
   end

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         state  <= IDLE;
         port   <= '0;
         drop_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (port_ld)  port   <= route;
         if (drop_pop) drop_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      port_ld   = 1'b0;
      drop_pop  = 1'b0;
      fwd_pop   = 1'b0;
      o_request = '0;
      out_valid = '0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               if (head_hdr) begin
                  port_ld   = 1'b1;
                  state_nxt = REQ;
               end else begin
                  drop_pop  = 1'b1;
               end
            end
         end
         REQ: begin
            o_request = port;
            if (|(i_grant & port)) state_nxt = XFER;
         end
         XFER: begin
            o_request = port;
            if (!empty && |(i_grant & port)) begin
               out_valid = port;
               if (|(out_ready & port)) begin
                  fwd_pop = 1'b1;
                  if (head_tail) state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_drop = drop_q;

`ifdef NOC_IN_PORT_PKT_CNT_EN
   logic [15:0] pkt_cnt;

   always_ff @(posedge noc_clk) begin
      if (noc_rst)                    pkt_cnt <= '0;
      else if (fwd_pop && head_tail)  pkt_cnt <= pkt_cnt + 16'd1;
   end

   assign o_pkt_cnt = pkt_cnt;
`else
   assign o_pkt_cnt = '0;
`endif

endmodule
